mode_counter: RTL and testbench

Parametrised N-bit counter with a programmable modulus, selectable count mode (up, down, ping-pong, hold), synchronous load, and wrap or saturate at the limits. It emits registered terminal-count and direction flags. It supersedes the plain free-running up counter for timers, address generators and scan sequencers. Single clock domain.

---
 rtl/mode_counter.sv | 155 +++++++++++++++
 tb/tb_mode_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Modulus counter with up/down/ping-pong/hold modes, load, wrap/saturate and registered flags.
// Optional build macro MODE_COUNTER_PRESCALE_EN adds a PRE_DIV enable prescaler.
module mode_counter #(
  parameter int unsigned N       = 8,
  parameter int unsigned MAX     = (2 ** N) - 1,
  parameter int unsigned PRE_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [1:0]   mode,
  input  logic         sat,
  output logic [N-1:0] counter,
  output logic         dir,
  output logic         tc
);

  typedef enum logic [1:0] {
    ModeUp   = 2'b00,
    ModeDown = 2'b01,
    ModePing = 2'b10,
    ModeHold = 2'b11
  } mode_e;

  localparam logic [N-1:0] MaxV = N'(MAX);

  if (N < 2 || MAX < 1 || PRE_DIV < 1) begin : g_param_check
    $error("mode_counter: illegal parameter set");
  end

  logic [N-1:0] r_cnt;
  logic         r_dir;
  logic         r_tc;

  logic [N-1:0] w_cnt_d;
  logic         w_dir_d;
  logic         w_tc_d;
  logic         w_tick;
  logic         w_step;
  mode_e        w_mode;

  assign w_mode = mode_e'(mode);

`ifdef MODE_COUNTER_PRESCALE_EN
  localparam int unsigned    PreW    = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRE_DIV - 1);

  logic [PreW-1:0] r_pre;
  logic            w_pre_wrap;

  assign w_pre_wrap = (r_pre == PreLast);

  // Prescaler counts every enabled cycle, even in hold mode; load restarts the division.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
    end
  end

  assign w_tick = w_pre_wrap;
`else
  assign w_tick = 1'b1;
`endif

  assign w_step = en && !load && (w_mode != ModeHold) && w_tick;

  always_comb begin
    w_cnt_d = r_cnt;
    w_dir_d = r_dir;
    w_tc_d  = 1'b0;
    if (load) begin
      w_cnt_d = (load_val > MaxV) ? MaxV : load_val;
    end else if (w_step) begin
      unique case (w_mode)
        ModeUp: begin
          w_dir_d = 1'b1;
          if (r_cnt > MaxV) begin
            w_cnt_d = '0;
            w_tc_d  = 1'b1;
          end else if (r_cnt == MaxV) begin
            w_cnt_d = sat ? MaxV : '0;
            w_tc_d  = 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        ModeDown: begin
          w_dir_d = 1'b0;
          if (r_cnt > MaxV) begin
            w_cnt_d = MaxV;
            w_tc_d  = 1'b1;
          end else if (r_cnt == '0) begin
            w_cnt_d = sat ? '0 : MaxV;
            w_tc_d  = 1'b1;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        ModePing: begin
          // Out-of-range values recover like up/down, keeping the current direction.
          if (r_dir) begin
            if (r_cnt > MaxV) begin
              w_cnt_d = '0;
              w_tc_d  = 1'b1;
            end else if (r_cnt == MaxV) begin
              w_cnt_d = MaxV - 1'b1;
              w_dir_d = 1'b0;
              w_tc_d  = 1'b1;
            end else begin
              w_cnt_d = r_cnt + 1'b1;
            end
          end else begin
            if (r_cnt > MaxV) begin
              w_cnt_d = MaxV;
              w_tc_d  = 1'b1;
            end else if (r_cnt == '0) begin
              w_cnt_d = {{(N-1){1'b0}}, 1'b1};
              w_dir_d = 1'b1;
              w_tc_d  = 1'b1;
            end else begin
              w_cnt_d = r_cnt - 1'b1;
            end
          end
        end
        ModeHold: begin
          w_cnt_d = r_cnt;
        end
        default: begin
          w_cnt_d = r_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dir <= 1'b1;
      r_tc  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_dir <= w_dir_d;
      r_tc  <= w_tc_d;
    end
  end

  assign counter = r_cnt;
  assign dir     = r_dir;
  assign tc      = r_tc;

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter (N=4, MAX=9); prescaler steps run when
// MODE_COUNTER_PRESCALE_EN is defined (PRE_DIV=3).
module tb_mode_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [1:0] mode;
  logic       sat;
  logic [3:0] counter;
  logic       dir;
  logic       tc;

  typedef struct packed {
    logic [3:0] cnt;
    logic       dir;
    logic       tc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  mode_counter #(
    .N      (4),
    .MAX    (9),
    .PRE_DIV(3)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .mode    (mode),
    .sat     (sat),
    .counter (counter),
    .dir     (dir),
    .tc      (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out();
    exp_t  e;
    exp_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = '{cnt: counter, dir: dir, tc: tc};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed cnt=%0d dir=%0b tc=%0b expected cnt=%0d dir=%0b tc=%0b",
             t, o.cnt, o.dir, o.tc, e.cnt, e.dir, e.tc);
    end
  endtask

  // One clock of stimulus; expectation is queued with the stimulus and checked after the edge.
  task automatic drive(input logic r, input logic e, input logic l, input logic [3:0] lv,
                       input logic [1:0] m, input logic s, input logic [3:0] ec,
                       input logic ed, input logic et, input string tag);
    @(negedge clk);
    reset    = r;
    en       = e;
    load     = l;
    load_val = lv;
    mode     = m;
    sat      = s;
    exp_q.push_back('{cnt: ec, dir: ed, tc: et});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    mode     = 2'b00;
    sat      = 1'b0;

`ifdef MODE_COUNTER_PRESCALE_EN
    drive(1, 0, 0, 0, 2'b00, 0, 4'd0, 1, 0, "pre_reset");
    for (int k = 1; k <= 9; k++) begin
      drive(0, 1, 0, 0, 2'b00, 0, 4'(k / 3), 1, 0, "pre_run");
    end
    drive(1, 0, 0, 0, 2'b00, 0, 4'd0, 1, 0, "pre_reset2");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd0, 1, 0, "pre_gap_a");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd0, 1, 0, "pre_gap_a");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd1, 1, 0, "pre_gap_a");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd1, 1, 0, "pre_gap_a");
    drive(0, 0, 0, 0, 2'b00, 0, 4'd1, 1, 0, "pre_gap_off");
    drive(0, 0, 0, 0, 2'b00, 0, 4'd1, 1, 0, "pre_gap_off");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd1, 1, 0, "pre_gap_b");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd2, 1, 0, "pre_gap_b");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd2, 1, 0, "pre_load_clr");
    drive(0, 1, 1, 4'd5, 2'b00, 0, 4'd5, 1, 0, "pre_load");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd5, 1, 0, "pre_after_load");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd5, 1, 0, "pre_after_load");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd6, 1, 0, "pre_after_load");
`else
    // Reset, then up/wrap.
    drive(1, 0, 0, 0, 2'b00, 0, 4'd0, 1, 0, "reset");
    for (int i = 1; i <= 12; i++) begin
      drive(0, 1, 0, 0, 2'b00, 0, 4'(i % 10), 1, (i == 10), "up_wrap");
    end

    // Down with saturation.
    drive(0, 0, 1, 4'd2, 2'b01, 1, 4'd2, 1, 0, "down_load");
    drive(0, 1, 0, 0, 2'b01, 1, 4'd1, 0, 0, "down_sat");
    drive(0, 1, 0, 0, 2'b01, 1, 4'd0, 0, 0, "down_sat");
    drive(0, 1, 0, 0, 2'b01, 1, 4'd0, 0, 1, "down_sat");
    drive(0, 1, 0, 0, 2'b01, 1, 4'd0, 0, 1, "down_sat");

    // Ping-pong from 0 after reset.
    drive(1, 0, 0, 0, 2'b10, 0, 4'd0, 1, 0, "pp_reset");
    for (int i = 1; i <= 20; i++) begin
      if (i <= 9) begin
        drive(0, 1, 0, 0, 2'b10, 0, 4'(i), 1, 0, "pingpong");
      end else if (i <= 18) begin
        drive(0, 1, 0, 0, 2'b10, 0, 4'(18 - i), 0, (i == 10), "pingpong");
      end else begin
        drive(0, 1, 0, 0, 2'b10, 0, 4'(i - 18), 1, (i == 19), "pingpong");
      end
    end

    // Load clamp beats en, then wrap from MAX.
    drive(0, 1, 1, 4'd14, 2'b00, 0, 4'd9, 1, 0, "load_clamp");
    drive(0, 1, 0, 0, 2'b00, 0, 4'd0, 1, 1, "clamp_wrap");

    // Reset wins over load and en.
    drive(0, 0, 1, 4'd5, 2'b00, 0, 4'd5, 1, 0, "load5");
    drive(1, 1, 1, 4'd7, 2'b01, 0, 4'd0, 1, 0, "reset_wins");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 2'b01, 0, 4'd0, 1, 0, "idle_hold");
    end

    // Hold mode, up saturation, down wrap, ping-pong keeps dir.
    drive(0, 0, 1, 4'd4, 2'b11, 0, 4'd4, 1, 0, "load4");
    drive(0, 1, 0, 0, 2'b11, 0, 4'd4, 1, 0, "mode_hold");
    drive(0, 0, 1, 4'd9, 2'b00, 1, 4'd9, 1, 0, "load9");
    drive(0, 1, 0, 0, 2'b00, 1, 4'd9, 1, 1, "up_sat");
    drive(0, 0, 1, 4'd0, 2'b01, 0, 4'd0, 1, 0, "load0");
    drive(0, 1, 0, 0, 2'b01, 0, 4'd9, 0, 1, "down_wrap");
    drive(0, 1, 0, 0, 2'b10, 0, 4'd8, 0, 0, "pp_keep_dir");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
